// File: rtl/des_pkg.sv
// Shared DES definitions: widths, FSM state type, permutation tables and the
// bit-order helpers used by the round controller and its key schedule.
package des_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 64;
  localparam int HALF_W  = 32;
  localparam int CD_W    = 28;
  localparam int RK_W    = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } des_state_t;

  // Table entries use DES numbering: position 1 is the MSB of the vector.
  localparam int unsigned IP_TABLE [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int unsigned FP_TABLE [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int unsigned PC1_TABLE [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TABLE [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int unsigned SHIFT_SCHEDULE [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  function automatic logic [BLOCK_W-1:0] ip_perm(input logic [BLOCK_W-1:0] d);
    logic [BLOCK_W-1:0] p;
    for (int j = 0; j < 64; j++) p[6'(63 - j)] = d[6'(64 - IP_TABLE[j])];
    return p;
  endfunction

  function automatic logic [BLOCK_W-1:0] fp_perm(input logic [BLOCK_W-1:0] d);
    logic [BLOCK_W-1:0] p;
    for (int j = 0; j < 64; j++) p[6'(63 - j)] = d[6'(64 - FP_TABLE[j])];
    return p;
  endfunction

  // Parity bits (8,16,..,64) never appear in PC1, so they drop out here.
  function automatic logic [2*CD_W-1:0] pc1_perm(input logic [KEY_W-1:0] k);
    logic [2*CD_W-1:0] p;
    for (int j = 0; j < 56; j++) p[6'(55 - j)] = k[6'(64 - PC1_TABLE[j])];
    return p;
  endfunction

  function automatic logic [RK_W-1:0] pc2_perm(input logic [2*CD_W-1:0] cd);
    logic [RK_W-1:0] p;
    for (int j = 0; j < 48; j++) p[6'(47 - j)] = cd[6'(56 - PC2_TABLE[j])];
    return p;
  endfunction

  function automatic logic [CD_W-1:0] rot_left(input logic [CD_W-1:0] v, input logic [1:0] n);
    case (n)
      2'd1:    rot_left = {v[CD_W-2:0], v[CD_W-1]};
      2'd2:    rot_left = {v[CD_W-3:0], v[CD_W-1:CD_W-2]};
      default: rot_left = v;
    endcase
  endfunction

  function automatic logic [CD_W-1:0] rot_right(input logic [CD_W-1:0] v, input logic [1:0] n);
    case (n)
      2'd1:    rot_right = {v[0], v[CD_W-1:1]};
      2'd2:    rot_right = {v[1:0], v[CD_W-1:2]};
      default: rot_right = v;
    endcase
  endfunction

endpackage

// File: rtl/des_key_schedule.sv
// DES key schedule: holds C/D halves, emits the round key for the current round.
// Decryption ordering (K16..K1) is built only when DES_DECRYPT_EN is defined.
module des_key_schedule
  import des_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             decrypt,
  input  logic [KEY_W-1:0] key,
  input  logic [3:0]       round,
  output logic [RK_W-1:0]  round_key
);

  logic [CD_W-1:0] c_q, d_q;
  logic [CD_W-1:0] c_sh, d_sh;
  logic [1:0]      enc_amt, dec_amt;
  logic            mode;

`ifdef DES_DECRYPT_EN
  logic mode_q;

  always_ff @(posedge clk) begin
    if (reset)     mode_q <= 1'b0;
    else if (load) mode_q <= decrypt;
  end

  assign mode = mode_q;
`else
  logic unused_decrypt;

  assign unused_decrypt = decrypt;
  assign mode           = 1'b0;
`endif

  // Decrypt: first round unshifted, then the encrypt schedule walked backwards.
  assign enc_amt = 2'(SHIFT_SCHEDULE[round]);
  assign dec_amt = (round == 4'd0) ? 2'd0 : 2'(SHIFT_SCHEDULE[~round + 4'd1]);

  always_comb begin
    c_sh = rot_left(c_q, enc_amt);
    d_sh = rot_left(d_q, enc_amt);
    if (mode) begin
      c_sh = rot_right(c_q, dec_amt);
      d_sh = rot_right(d_q, dec_amt);
    end
  end

  assign round_key = pc2_perm({c_sh, d_sh});

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q <= '0;
      d_q <= '0;
    end else if (load) begin
      {c_q, d_q} <= pc1_perm(key);
    end else if (step) begin
      c_q <= c_sh;
      d_q <= d_sh;
    end
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES sequencer: one Feistel round per clock through an external f-unit.
// Build option DES_DECRYPT_EN enables decryption via wDecrypt.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic               wClk,
  input  logic               wReset,
  input  logic               wInValid,
  output logic               wInReady,
  input  logic [BLOCK_W-1:0] wInData,
  input  logic [KEY_W-1:0]   wInKey,
  input  logic               wDecrypt,
  output logic [HALF_W-1:0]  wFeistelR,
  output logic [RK_W-1:0]    wRoundKey,
  input  logic [HALF_W-1:0]  wFeistelOut,
  output logic               wOutValid,
  input  logic               wOutReady,
  output logic [BLOCK_W-1:0] wOutData,
  output logic [3:0]         wRound
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  des_state_t         state_q, state_d;
  logic [HALF_W-1:0]  l_q, r_q;
  logic [3:0]         cnt_q;
  logic [BLOCK_W-1:0] out_data_q;
  logic               accept, load_key, step_key, last_round;

  assign wInReady   = (state_q == IDLE) && !wReset;
  assign accept     = wInValid && wInReady;
  assign last_round = (cnt_q == LAST_ROUND);

  always_ff @(posedge wClk) begin
    if (wReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_key = 1'b0;
    step_key = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = ROUND;
          load_key = 1'b1;
        end
      end
      ROUND: begin
        step_key = 1'b1;
        if (last_round) state_d = DONE;
      end
      DONE: begin
        if (wOutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result is captured on the final round edge with the usual R16||L16 swap.
  always_ff @(posedge wClk) begin
    if (wReset) begin
      l_q        <= '0;
      r_q        <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else if (load_key) begin
      {l_q, r_q} <= ip_perm(wInData);
      cnt_q      <= '0;
    end else if (step_key) begin
      l_q   <= r_q;
      r_q   <= l_q ^ wFeistelOut;
      cnt_q <= cnt_q + 4'd1;
      if (last_round) out_data_q <= fp_perm({l_q ^ wFeistelOut, r_q});
    end
  end

  des_key_schedule u_key_schedule (
    .clk       (wClk),
    .reset     (wReset),
    .load      (load_key),
    .step      (step_key),
    .decrypt   (wDecrypt),
    .key       (wInKey),
    .round     (cnt_q),
    .round_key (wRoundKey)
  );

  assign wFeistelR = r_q;
  assign wOutValid = (state_q == DONE);
  assign wOutData  = out_data_q;
  assign wRound    = cnt_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: supplies the DES f-unit and checks known-answer vectors
// plus handshake, stall, abort and back-to-back sequences.
module tb_des_round_ctrl;

  logic        clk, rst, in_valid, in_ready, dec, out_valid, out_ready;
  logic [63:0] in_data, in_key, out_data;
  logic [31:0] feistel_r, feistel_out;
  logic [47:0] round_key;
  logic [3:0]  round;

  int passed = 0;
  int total  = 0;

  localparam int E_TABLE [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1
  };

  localparam int P_TABLE [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
  };

  localparam int SBOX [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11
  };

  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s, p;
    logic [5:0]  b;
    int          idx;
    for (int j = 0; j < 48; j++) e[6'(47 - j)] = r[5'(32 - E_TABLE[j])];
    e = e ^ k;
    for (int i = 0; i < 8; i++) begin
      b   = e[6'(47 - 6 * i) -: 6];
      idx = i * 64 + int'({b[5], b[0]}) * 16 + int'(b[4:1]);
      s[5'(31 - 4 * i) -: 4] = 4'(SBOX[idx]);
    end
    for (int j = 0; j < 32; j++) p[5'(31 - j)] = s[5'(32 - P_TABLE[j])];
    return p;
  endfunction

  always_comb feistel_out = f_func(feistel_r, round_key);

  des_round_ctrl dut (
    .wClk        (clk),
    .wReset      (rst),
    .wInValid    (in_valid),
    .wInReady    (in_ready),
    .wInData     (in_data),
    .wInKey      (in_key),
    .wDecrypt    (dec),
    .wFeistelR   (feistel_r),
    .wRoundKey   (round_key),
    .wFeistelOut (feistel_out),
    .wOutValid   (out_valid),
    .wOutReady   (out_ready),
    .wOutData    (out_data),
    .wRound      (round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [63:0] key;
    logic [63:0] data;
    logic        dec;
    logic [63:0] expect_out;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic start_block(input logic [63:0] key, input logic [63:0] data, input logic d);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_key   = key;
    in_data  = data;
    dec      = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~data;
    in_key   = ~key;
    dec      = ~d;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
  endtask

  task automatic take_result(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({name, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;

  initial begin
    int n;
    logic [63:0] held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_key = '0; dec = 1'b0;

    vecs.push_back('{"fips_example", K1, P1, 1'b0, C1});
    vecs.push_back('{"parity_flip", 64'h123556789ABDDEF0, P1, 1'b0, C1});
    vecs.push_back('{"zero", 64'h0, 64'h0, 1'b0, 64'h8CA64DE9C1B123A7});
    vecs.push_back('{"ones", 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h7359B2163E4EDC58});
    vecs.push_back('{"rivest3", 64'h3000000000000000, 64'h1000000000000001, 1'b0, 64'h958E6E627A05557B});
    vecs.push_back('{"all11", 64'h1111111111111111, 64'h1111111111111111, 1'b0, 64'hF40379AB9E0EC533});
    vecs.push_back('{"key0123", P1, 64'h1111111111111111, 1'b0, 64'h17668DFC7292532D});
    vecs.push_back('{"keyfedc", 64'hFEDCBA9876543210, P1, 1'b0, 64'hED39D950FA74BCC4});
`ifdef DES_DECRYPT_EN
    vecs.push_back('{"dec_fips", K1, C1, 1'b1, P1});
    vecs.push_back('{"dec_zero", 64'h0, 64'h8CA64DE9C1B123A7, 1'b1, 64'h0});
    vecs.push_back('{"dec_fedc", 64'hFEDCBA9876543210, 64'hED39D950FA74BCC4, 1'b1, P1});
`else
    vecs.push_back('{"dec_ignored", K1, P1, 1'b1, C1});
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_round", 64'(round), 64'd0);
    check("rst_feistel_r", 64'(feistel_r), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Round keys, latency and result of the reference block
    start_block(K1, P1, 1'b0);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("rk_round1", 64'(round_key), 64'h1B02EFFC7072);
        check("round_idx1", 64'(round), 64'd0);
      end
      if (c == 8) begin
        check("mid_out_valid", 64'(out_valid), 64'd0);
        check("mid_in_ready", 64'(in_ready), 64'd0);
      end
      if (c == 16) begin
        check("rk_round16", 64'(round_key), 64'hCB3D8B0E17F5);
        check("round_idx16", 64'(round), 64'd15);
        check("pre_done_valid", 64'(out_valid), 64'd0);
      end
    end
    check("lat17_valid", 64'(out_valid), 64'd1);
    check("ref_data", out_data, C1);
    take_result("ref");

    // Known-answer table
    for (int i = 0; i < vecs.size(); i++) begin
      start_block(vecs[i].key, vecs[i].data, vecs[i].dec);
      wait_valid(n);
      check($sformatf("%s_latency", vecs[i].name), 64'(n), 64'd17);
      check($sformatf("%s_data", vecs[i].name), out_data, vecs[i].expect_out);
      take_result(vecs[i].name);
    end

    // Consumer stall, ignored input during ROUND/DONE, early out_ready
    start_block(K1, P1, 1'b0);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 5) begin
        in_valid = 1'b1; in_data = 64'hFFFFFFFFFFFFFFFF; in_key = 64'h0; out_ready = 1'b1;
      end
      if (c == 6) out_ready = 1'b0;
    end
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_data0", out_data, C1);
    held = out_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("stall_valid_%0d", c), 64'(out_valid), 64'd1);
      check($sformatf("stall_data_%0d", c), out_data, held);
      check($sformatf("stall_ready_%0d", c), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    take_result("stall");
    check("stall_round_idle", 64'(round), 64'd0);

    // Abort with reset at round 8, then a fresh block
    start_block(K1, P1, 1'b0);
    repeat (8) @(negedge clk);
    check("abort_round", 64'(round), 64'd7);
    rst = 1'b1;
    #1;
    check("abort_ready_in_rst", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_round0", 64'(round), 64'd0);
    check("abort_feistel_r", 64'(feistel_r), 64'd0);
    check("abort_out_data", out_data, 64'd0);
    repeat (20) @(negedge clk);
    check("abort_no_result", 64'(out_valid), 64'd0);
    start_block(64'h0, 64'h0, 1'b0);
    wait_valid(n);
    check("fresh_latency", 64'(n), 64'd17);
    check("fresh_data", out_data, 64'h8CA64DE9C1B123A7);
    take_result("fresh");

    // Back-to-back with out_ready held high
    out_ready = 1'b1;
    start_block(K1, P1, 1'b0);
    in_valid = 1'b1;
    in_key   = 64'h1111111111111111;
    in_data  = 64'h1111111111111111;
    dec      = 1'b0;
    wait_valid(n);
    check("b2b_a_latency", 64'(n), 64'd17);
    check("b2b_a_data", out_data, C1);
    @(negedge clk);
    check("b2b_gap_valid", 64'(out_valid), 64'd0);
    check("b2b_gap_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    in_key   = '0;
    wait_valid(n);
    check("b2b_b_latency", 64'(n), 64'd17);
    check("b2b_b_data", out_data, 64'hF40379AB9E0EC533);
    @(negedge clk);
    check("b2b_b_taken", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
